axi_master_txn_sched: RTL and testbench
=======================================

Name: axi_master_txn_sched

Overview:
- Multi-requester transaction scheduler in front of the AXI master's decoder-side command interface.
- Arbitrates NUM_REQ requesters independently on the write and read channels, using round-robin.
- Latches the granted command, issues a single-cycle wr_trn_en / rd_trn_en, and routes responses back to the owning requester.
- One outstanding transaction per direction; the write and read channels run concurrently.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 64, data width
TIMEOUT_CYC, 1024, response watchdog limit in cycles (used only with the optional feature)

Ports:
AClk  in  1  clock
ARst  in  1  synchronous active-high reset
req_wr_valid  in  NUM_REQ  per-requester write command valid
req_wr_ready  out  NUM_REQ  one-hot pulse: command accepted/issued
req_awaddr  in  NUM_REQ*ADDR_W  flattened write address, requester i at [i*ADDR_W+:ADDR_W]
req_awlen  in  NUM_REQ*8  burst length-1
req_awsize  in  NUM_REQ*3  beat size
req_awburst  in  NUM_REQ*2  burst type
req_wdata  in  NUM_REQ*DATA_W  write data
req_wstrb  in  NUM_REQ*8  write strobes
req_rd_valid  in  NUM_REQ  read command valid
req_rd_ready  out  NUM_REQ  one-hot pulse: read issued
req_araddr  in  NUM_REQ*ADDR_W  read address
req_arlen  in  NUM_REQ*8  read length-1
req_arsize  in  NUM_REQ*3  read size
req_arburst  in  NUM_REQ*2  read burst
wr_done  out  NUM_REQ  one-hot pulse: write response
wr_resp  out  2  response code, valid with wr_done
rd_beat  out  NUM_REQ  one-hot pulse per read beat
rd_data  out  DATA_W  read data, valid with rd_beat
rd_resp  out  2  read response, valid with rd_beat
rd_last  out  1  last beat, valid with rd_beat
id_err  out  1  sticky flag: bid_d/rid_d mismatch
TXN_ID_W_d  out  4  write ID = grant index
awaddr_d, awlen_d, awsize_d, awburst_d  out  ADDR_W/8/3/2  latched write command
awlock_d, awcache_d, awprot_d  out  2/2/3  constant 0
wdata_d  out  DATA_W  write data of grantee
wstrb_d  out  8  write strobes of grantee
wr_trn_en  out  1  write start pulse
bresp_d  in  2  write response
bid_d  in  4  write response ID
wr_rsp_en_d  in  1  write response valid
TXN_ID_R_d  out  4  read ID = grant index
araddr_d, arlen_d, arsize_d, arburst_d  out  ADDR_W/8/3/2  latched read command
arlock_d, arcache_d, arprot_d  out  2/2/3  constant 0
rd_trn_en  out  1  read start pulse
rdata_d  in  DATA_W  read data
rresp_d  in  2  read response
rid_d  in  8  read ID
rd_rsp_en_d  in  1  read beat valid
r_last_d  in  1  last read beat

Behaviour:
- Reset: all outputs 0, both FSMs in IDLE, both round-robin pointers 0, id_err cleared.
- Write FSM states: W_IDLE, W_ISSUE, W_WAIT.
  - W_IDLE: if any req_wr_valid is set, grant the first set bit at or above ptr_w (wrapping), register the command fields and go to W_ISSUE.
  - W_ISSUE, one cycle: wr_trn_en=1, req_wr_ready[g]=1, then go to W_WAIT.
  - W_WAIT: on wr_rsp_en_d, next cycle wr_done[g]=1 and wr_resp=bresp_d; if bid_d!=g, set id_err; ptr_w=(g+1) mod NUM_REQ; go to W_IDLE.
- Read FSM states: R_IDLE, R_ISSUE, R_WAIT.
  - R_IDLE / R_ISSUE: identical rules using the read signals and rd_trn_en.
  - R_WAIT: each rd_rsp_en_d cycle produces, next cycle, rd_beat[g]=1 with rd_data/rd_resp/rd_last registered from the master.
  - If rid_d[3:0]!=g or rid_d[7:4]!=0, set id_err.
  - rd_rsp_en_d with r_last_d completes the transaction: pointer update, then R_IDLE.
- Latency:
  - valid seen at edge k → trn_en high in cycle k+1.
  - Response in → requester pulse +1 cycle.
  - Next grant earliest 1 cycle after completion, i.e. back-to-back period of 3 cycles plus slave latency.
- Command fields are captured at grant. Deasserting valid after grant does not cancel the issue.
- wdata_d / wstrb_d: combinational mux of the grantee's data while the write FSM is not idle; 0 in W_IDLE.
- Responses arriving in IDLE or ISSUE are ignored: no pulse, no id_err.
- Write and read events in the same cycle are handled independently.
- ARst mid-transaction aborts to IDLE with no completion pulse. Late master responses are then ignored.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a per-channel counter runs in *_WAIT and is cleared on every response/beat.
- On reaching TIMEOUT_CYC, the block emits a completion pulse with resp=2'b10 (SLVERR) to the grantee; for reads, rd_last=1 and rd_data=0.
- The FSM returns to IDLE and the pointer advances.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Single write, requester 2, awaddr 0x1000, awlen 3 → wr_trn_en 1 cycle after valid, TXN_ID_W_d=2. bresp_d=0, bid_d=2 → wr_done=4'b0100 next cycle, wr_resp=0.
- All four requesters hold wr_valid → grant order 0,1,2,3,0; each req_wr_ready seen exactly once per transaction.
- Read arlen 3 for requester 1 → four rd_beat=4'b0010 pulses with data 0xA0..0xA3, rd_last only on the 4th; read FSM back to R_IDLE.
- Concurrent write (req 0) and read (req 3) in the same cycle → wr_trn_en and rd_trn_en in the same cycle; completions independent.
- bid_d=1 while grant=0 → wr_done still pulses for req 0, id_err=1 until ARst. ARst asserted in W_WAIT → outputs 0, ptr 0, a later wr_rsp_en_d produces no wr_done.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no response → wr_done pulses 16 cycles into W_WAIT with wr_resp=2'b10.

Source files
------------

// File: rtl/axi_master_txn_sched.sv
// Round-robin scheduler of NUM_REQ requesters onto the AXI master command interface, write and read arbitrated separately.
// Latency: valid sampled -> trn_en next cycle; master response -> requester pulse next cycle; 3-cycle issue period plus slave latency.
// Backpressure: one outstanding transaction per direction; other requesters hold valid until their one-cycle ready pulse.
//
// Ports:
//   AClk, ARst            clock, synchronous active-high reset
//   req_wr_* / req_aw*    per-requester write commands (flattened, requester i at slice i)
//   req_rd_* / req_ar*    per-requester read commands
//   wr_done/wr_resp       one-hot write completion pulse back to the owner
//   rd_beat/rd_data/...   one-hot read beat pulse back to the owner
//   id_err                sticky: response ID did not match the owning grant
//   *_d outputs           latched command towards the master, wr_trn_en/rd_trn_en start pulses
//   *_d inputs            master responses (bresp/bid, rdata/rresp/rid/last)
//
// Optional build macro ARB_TIMEOUT_EN: per-channel response watchdog of TIMEOUT_CYC
// cycles that completes the transaction with SLVERR when the master stays silent.
module axi_master_txn_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      AClk,
  input  logic                      ARst,
  input  logic [NUM_REQ-1:0]        req_wr_valid,
  output logic [NUM_REQ-1:0]        req_wr_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_awaddr,
  input  logic [NUM_REQ*8-1:0]      req_awlen,
  input  logic [NUM_REQ*3-1:0]      req_awsize,
  input  logic [NUM_REQ*2-1:0]      req_awburst,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*8-1:0]      req_wstrb,
  input  logic [NUM_REQ-1:0]        req_rd_valid,
  output logic [NUM_REQ-1:0]        req_rd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]      req_arlen,
  input  logic [NUM_REQ*3-1:0]      req_arsize,
  input  logic [NUM_REQ*2-1:0]      req_arburst,
  output logic [NUM_REQ-1:0]        wr_done,
  output logic [1:0]                wr_resp,
  output logic [NUM_REQ-1:0]        rd_beat,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                rd_resp,
  output logic                      rd_last,
  output logic                      id_err,
  output logic [3:0]                TXN_ID_W_d,
  output logic [ADDR_W-1:0]         awaddr_d,
  output logic [7:0]                awlen_d,
  output logic [2:0]                awsize_d,
  output logic [1:0]                awburst_d,
  output logic [1:0]                awlock_d,
  output logic [1:0]                awcache_d,
  output logic [2:0]                awprot_d,
  output logic [DATA_W-1:0]         wdata_d,
  output logic [7:0]                wstrb_d,
  output logic                      wr_trn_en,
  input  logic [1:0]                bresp_d,
  input  logic [3:0]                bid_d,
  input  logic                      wr_rsp_en_d,
  output logic [3:0]                TXN_ID_R_d,
  output logic [ADDR_W-1:0]         araddr_d,
  output logic [7:0]                arlen_d,
  output logic [2:0]                arsize_d,
  output logic [1:0]                arburst_d,
  output logic [1:0]                arlock_d,
  output logic [1:0]                arcache_d,
  output logic [2:0]                arprot_d,
  output logic                      rd_trn_en,
  input  logic [DATA_W-1:0]         rdata_d,
  input  logic [1:0]                rresp_d,
  input  logic [7:0]                rid_d,
  input  logic                      rd_rsp_en_d,
  input  logic                      r_last_d
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("axi_master_txn_sched: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} r_state_t;

  w_state_t           w_state, w_state_nxt;
  r_state_t           r_state, r_state_nxt;
  logic [IDX_W-1:0]   w_gnt, r_gnt, ptr_w, ptr_r, w_pick, r_pick;
  logic               w_take, w_cmpl, w_bad_id;
  logic [1:0]         w_cmpl_resp;
  logic               r_take, r_beat, r_cmpl, r_bad_id, r_beat_last;
  logic [1:0]         r_beat_resp;
  logic [DATA_W-1:0]  r_beat_dat;

  // First requesting index at or above ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && vld[j]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
    return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  assign w_pick = rr_pick(req_wr_valid, ptr_w);
  assign r_pick = rr_pick(req_rd_valid, ptr_r);

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] w_tmo_cnt, r_tmo_cnt;
  logic             w_tmo_hit, r_tmo_hit;

  // Counters restart on every master response so only silence is timed.
  always_ff @(posedge AClk) begin
    if (ARst || w_state != W_WAIT || wr_rsp_en_d) w_tmo_cnt <= '0;
    else                                          w_tmo_cnt <= w_tmo_cnt + 1'b1;
    if (ARst || r_state != R_WAIT || rd_rsp_en_d) r_tmo_cnt <= '0;
    else                                          r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo_hit = (w_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign r_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`endif

  // ---------------- write channel ----------------
  always_comb begin
    w_state_nxt  = w_state;
    w_take       = 1'b0;
    w_cmpl       = 1'b0;
    w_cmpl_resp  = 2'b00;
    w_bad_id     = 1'b0;
    wr_trn_en    = 1'b0;
    req_wr_ready = '0;
    case (w_state)
      W_IDLE: begin
        if (|req_wr_valid) begin
          w_take      = 1'b1;
          w_state_nxt = W_ISSUE;
        end
      end
      W_ISSUE: begin
        wr_trn_en    = 1'b1;
        req_wr_ready = NUM_REQ'(1) << w_gnt;
        w_state_nxt  = W_WAIT;
      end
      W_WAIT: begin
        if (wr_rsp_en_d) begin
          w_cmpl      = 1'b1;
          w_cmpl_resp = bresp_d;
          w_bad_id    = (bid_d != 4'(w_gnt));
          w_state_nxt = W_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_cmpl      = 1'b1;
          w_cmpl_resp = 2'b10;
          w_state_nxt = W_IDLE;
        end
`endif
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge AClk) begin
    if (ARst) begin
      w_state   <= W_IDLE;
      w_gnt     <= '0;
      ptr_w     <= '0;
      awaddr_d  <= '0;
      awlen_d   <= '0;
      awsize_d  <= '0;
      awburst_d <= '0;
      wr_done   <= '0;
      wr_resp   <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (w_take) begin
        w_gnt     <= w_pick;
        awaddr_d  <= req_awaddr[int'(w_pick)*ADDR_W +: ADDR_W];
        awlen_d   <= req_awlen[int'(w_pick)*8 +: 8];
        awsize_d  <= req_awsize[int'(w_pick)*3 +: 3];
        awburst_d <= req_awburst[int'(w_pick)*2 +: 2];
      end
      if (w_cmpl) ptr_w <= rr_next(w_gnt);
      wr_done <= w_cmpl ? (NUM_REQ'(1) << w_gnt) : '0;
      wr_resp <= w_cmpl_resp;
    end
  end

  // Write data is not latched: the owner keeps driving it until its transaction completes.
  assign wdata_d    = (w_state != W_IDLE) ? req_wdata[int'(w_gnt)*DATA_W +: DATA_W] : '0;
  assign wstrb_d    = (w_state != W_IDLE) ? req_wstrb[int'(w_gnt)*8 +: 8] : '0;
  assign TXN_ID_W_d = 4'(w_gnt);
  assign awlock_d   = '0;
  assign awcache_d  = '0;
  assign awprot_d   = '0;

  // ---------------- read channel ----------------
  always_comb begin
    r_state_nxt  = r_state;
    r_take       = 1'b0;
    r_beat       = 1'b0;
    r_cmpl       = 1'b0;
    r_bad_id     = 1'b0;
    r_beat_dat   = '0;
    r_beat_resp  = 2'b00;
    r_beat_last  = 1'b0;
    rd_trn_en    = 1'b0;
    req_rd_ready = '0;
    case (r_state)
      R_IDLE: begin
        if (|req_rd_valid) begin
          r_take      = 1'b1;
          r_state_nxt = R_ISSUE;
        end
      end
      R_ISSUE: begin
        rd_trn_en    = 1'b1;
        req_rd_ready = NUM_REQ'(1) << r_gnt;
        r_state_nxt  = R_WAIT;
      end
      R_WAIT: begin
        if (rd_rsp_en_d) begin
          r_beat      = 1'b1;
          r_beat_dat  = rdata_d;
          r_beat_resp = rresp_d;
          r_beat_last = r_last_d;
          // Upper ID nibble is never issued, so any set bit there is foreign.
          r_bad_id    = (rid_d[3:0] != 4'(r_gnt)) || (rid_d[7:4] != 4'd0);
          if (r_last_d) begin
            r_cmpl      = 1'b1;
            r_state_nxt = R_IDLE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_tmo_hit) begin
          r_beat      = 1'b1;
          r_beat_resp = 2'b10;
          r_beat_last = 1'b1;
          r_cmpl      = 1'b1;
          r_state_nxt = R_IDLE;
        end
`endif
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge AClk) begin
    if (ARst) begin
      r_state   <= R_IDLE;
      r_gnt     <= '0;
      ptr_r     <= '0;
      araddr_d  <= '0;
      arlen_d   <= '0;
      arsize_d  <= '0;
      arburst_d <= '0;
      rd_beat   <= '0;
      rd_data   <= '0;
      rd_resp   <= '0;
      rd_last   <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (r_take) begin
        r_gnt     <= r_pick;
        araddr_d  <= req_araddr[int'(r_pick)*ADDR_W +: ADDR_W];
        arlen_d   <= req_arlen[int'(r_pick)*8 +: 8];
        arsize_d  <= req_arsize[int'(r_pick)*3 +: 3];
        arburst_d <= req_arburst[int'(r_pick)*2 +: 2];
      end
      if (r_cmpl) ptr_r <= rr_next(r_gnt);
      rd_beat <= r_beat ? (NUM_REQ'(1) << r_gnt) : '0;
      rd_data <= r_beat_dat;
      rd_resp <= r_beat_resp;
      rd_last <= r_beat_last;
    end
  end

  assign TXN_ID_R_d = 4'(r_gnt);
  assign arlock_d   = '0;
  assign arcache_d  = '0;
  assign arprot_d   = '0;

  always_ff @(posedge AClk) begin
    if (ARst)                       id_err <= 1'b0;
    else if (w_bad_id || r_bad_id)  id_err <= 1'b1;
  end

endmodule

// File: tb/tb_axi_master_txn_sched.sv
module tb_axi_master_txn_sched;

  logic        AClk, ARst;
  logic [3:0]  req_wr_valid, req_wr_ready, req_rd_valid, req_rd_ready;
  logic [127:0] req_awaddr, req_araddr;
  logic [31:0] req_awlen, req_arlen, req_wstrb;
  logic [11:0] req_awsize, req_arsize;
  logic [7:0]  req_awburst, req_arburst;
  logic [255:0] req_wdata;
  logic [3:0]  wr_done, rd_beat;
  logic [1:0]  wr_resp, rd_resp;
  logic [63:0] rd_data, wdata_d, rdata_d;
  logic        rd_last, id_err, wr_trn_en, rd_trn_en;
  logic [3:0]  TXN_ID_W_d, TXN_ID_R_d, bid_d;
  logic [31:0] awaddr_d, araddr_d;
  logic [7:0]  awlen_d, arlen_d, wstrb_d, rid_d;
  logic [2:0]  awsize_d, arsize_d, awprot_d, arprot_d;
  logic [1:0]  awburst_d, arburst_d, awlock_d, arlock_d, awcache_d, arcache_d;
  logic [1:0]  bresp_d, rresp_d;
  logic        wr_rsp_en_d, rd_rsp_en_d, r_last_d;

  axi_master_txn_sched #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .TIMEOUT_CYC(1024)) dut (
    .AClk(AClk), .ARst(ARst),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awsize(req_awsize),
    .req_awburst(req_awburst), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
    .req_arburst(req_arburst),
    .wr_done(wr_done), .wr_resp(wr_resp), .rd_beat(rd_beat), .rd_data(rd_data),
    .rd_resp(rd_resp), .rd_last(rd_last), .id_err(id_err),
    .TXN_ID_W_d(TXN_ID_W_d), .awaddr_d(awaddr_d), .awlen_d(awlen_d), .awsize_d(awsize_d),
    .awburst_d(awburst_d), .awlock_d(awlock_d), .awcache_d(awcache_d), .awprot_d(awprot_d),
    .wdata_d(wdata_d), .wstrb_d(wstrb_d), .wr_trn_en(wr_trn_en),
    .bresp_d(bresp_d), .bid_d(bid_d), .wr_rsp_en_d(wr_rsp_en_d),
    .TXN_ID_R_d(TXN_ID_R_d), .araddr_d(araddr_d), .arlen_d(arlen_d), .arsize_d(arsize_d),
    .arburst_d(arburst_d), .arlock_d(arlock_d), .arcache_d(arcache_d), .arprot_d(arprot_d),
    .rd_trn_en(rd_trn_en), .rdata_d(rdata_d), .rresp_d(rresp_d), .rid_d(rid_d),
    .rd_rsp_en_d(rd_rsp_en_d), .r_last_d(r_last_d)
  );

  initial AClk = 1'b0;
  always #5 AClk = ~AClk;

  typedef struct packed { logic [3:0] mask; logic [3:0] idx; logic [31:0] addr;
                          logic [7:0] len; logic [2:0] size; logic [1:0] burst; } iss_t;
  typedef struct packed { logic [3:0] mask; logic [1:0] resp; } done_t;
  typedef struct packed { logic [3:0] mask; logic [63:0] data; logic [1:0] resp; logic last; } beat_t;
  typedef struct { logic rd; int r; logic [31:0] addr; logic [7:0] len; logic [7:0] id;
                   logic [1:0] resp; logic [63:0] data; logic [3:0] exp_mask; logic exp_err; } vec_t;

  iss_t  wr_iss_q[$], rd_iss_q[$];
  done_t done_q[$];
  beat_t beat_q[$];
  iss_t  m_iss;
  done_t m_done, t_done;
  beat_t m_beat, t_beat;
  vec_t  vt[6];
  int    n_cmp = 0, n_err = 0, lat;
  int    order[5];
  logic [3:0] seen;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  task automatic set_wr(input int r, input logic [31:0] a, input logic [7:0] l,
                        input logic [63:0] d, input logic [7:0] s);
    req_awaddr[r*32 +: 32] = a;
    req_awlen[r*8 +: 8]    = l;
    req_awsize[r*3 +: 3]   = 3'(r + 1);
    req_awburst[r*2 +: 2]  = 2'b01;
    req_wdata[r*64 +: 64]  = d;
    req_wstrb[r*8 +: 8]    = s;
    req_wr_valid[r]        = 1'b1;
  endtask

  task automatic exp_wr_iss(input int r, input logic [31:0] a, input logic [7:0] l);
    iss_t e;
    e.mask = 4'(1 << r); e.idx = 4'(r); e.addr = a; e.len = l;
    e.size = 3'(r + 1); e.burst = 2'b01;
    wr_iss_q.push_back(e);
  endtask

  task automatic set_rd(input int r, input logic [31:0] a, input logic [7:0] l);
    iss_t e;
    req_araddr[r*32 +: 32] = a;
    req_arlen[r*8 +: 8]    = l;
    req_arsize[r*3 +: 3]   = 3'(r + 1);
    req_arburst[r*2 +: 2]  = 2'b01;
    req_rd_valid[r]        = 1'b1;
    e.mask = 4'(1 << r); e.idx = 4'(r); e.addr = a; e.len = l;
    e.size = 3'(r + 1); e.burst = 2'b01;
    rd_iss_q.push_back(e);
  endtask

  // Counts falling edges until the requested start pulse; 0 means it never came.
  task automatic issue_wait(input logic rd, output int n_out);
    n_out = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge AClk);
      if (rd ? rd_trn_en : wr_trn_en) begin
        n_out = n;
        break;
      end
    end
    if (n_out == 0) fail_now(rd ? "rd_issue_timeout" : "wr_issue_timeout");
  endtask

  // Scoreboard side: every pulse the DUT produces must match the head of its queue.
  always @(negedge AClk) begin
    if (!ARst) begin
      if (wr_trn_en) begin
        if (wr_iss_q.size() == 0) fail_now("wr_issue_unexpected");
        else begin
          m_iss = wr_iss_q.pop_front();
          check("wr_ready", 64'(req_wr_ready), 64'(m_iss.mask));
          check("wr_id", 64'(TXN_ID_W_d), 64'(m_iss.idx));
          check("awaddr", 64'(awaddr_d), 64'(m_iss.addr));
          check("awlen_size_burst", 64'({awlen_d, awsize_d, awburst_d}),
                64'({m_iss.len, m_iss.size, m_iss.burst}));
        end
      end else if (req_wr_ready != 4'd0) check("wr_ready_idle", 64'(req_wr_ready), 64'd0);
      if (rd_trn_en) begin
        if (rd_iss_q.size() == 0) fail_now("rd_issue_unexpected");
        else begin
          m_iss = rd_iss_q.pop_front();
          check("rd_ready", 64'(req_rd_ready), 64'(m_iss.mask));
          check("rd_id", 64'(TXN_ID_R_d), 64'(m_iss.idx));
          check("araddr", 64'(araddr_d), 64'(m_iss.addr));
          check("arlen_size_burst", 64'({arlen_d, arsize_d, arburst_d}),
                64'({m_iss.len, m_iss.size, m_iss.burst}));
        end
      end else if (req_rd_ready != 4'd0) check("rd_ready_idle", 64'(req_rd_ready), 64'd0);
      if (wr_done != 4'd0) begin
        if (done_q.size() == 0) fail_now("wr_done_unexpected");
        else begin
          m_done = done_q.pop_front();
          check("wr_done", 64'(wr_done), 64'(m_done.mask));
          check("wr_resp", 64'(wr_resp), 64'(m_done.resp));
        end
      end
      if (rd_beat != 4'd0) begin
        if (beat_q.size() == 0) fail_now("rd_beat_unexpected");
        else begin
          m_beat = beat_q.pop_front();
          check("rd_beat", 64'(rd_beat), 64'(m_beat.mask));
          check("rd_data", rd_data, m_beat.data);
          check("rd_resp_last", 64'({rd_resp, rd_last}), 64'({m_beat.resp, m_beat.last}));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ARst = 1'b1;
    req_wr_valid = '0; req_rd_valid = '0;
    req_awaddr = '0; req_araddr = '0; req_awlen = '0; req_arlen = '0;
    req_awsize = '0; req_arsize = '0; req_awburst = '0; req_arburst = '0;
    req_wdata = '0; req_wstrb = '0;
    bresp_d = '0; bid_d = '0; wr_rsp_en_d = 1'b0;
    rdata_d = '0; rresp_d = '0; rid_d = '0; rd_rsp_en_d = 1'b0; r_last_d = 1'b0;

    //          rd    r  addr          len  id     resp   data                 mask     err
    vt[0] = '{1'b0, 2, 32'h0000_1000, 8'd3, 8'h02, 2'b00, 64'hDEAD_BEEF_0000_0002, 4'b0100, 1'b0};
    vt[1] = '{1'b0, 0, 32'h0000_2000, 8'd0, 8'h00, 2'b01, 64'h0123_4567_89AB_CDEF, 4'b0001, 1'b0};
    vt[2] = '{1'b0, 3, 32'h0000_3000, 8'd7, 8'h03, 2'b10, 64'hFFFF_0000_FFFF_0000, 4'b1000, 1'b0};
    vt[3] = '{1'b1, 1, 32'h0000_4000, 8'd0, 8'h01, 2'b00, 64'h0000_0000_0000_00C1, 4'b0010, 1'b0};
    vt[4] = '{1'b1, 3, 32'h0000_5000, 8'd0, 8'h03, 2'b11, 64'h5555_AAAA_5555_AAAA, 4'b1000, 1'b0};
    vt[5] = '{1'b1, 2, 32'h0000_6000, 8'd0, 8'h12, 2'b00, 64'h0000_0000_0000_0066, 4'b0100, 1'b1};

    repeat (3) @(posedge AClk);
    @(negedge AClk);
    check("rst_trn_en", 64'({wr_trn_en, rd_trn_en}), 64'd0);
    check("rst_pulses", 64'({wr_done, rd_beat, req_wr_ready, req_rd_ready}), 64'd0);
    check("rst_id_err", 64'(id_err), 64'd0);
    check("rst_cmd", 64'({awaddr_d, TXN_ID_W_d, TXN_ID_R_d}), 64'd0);
    check("rst_wdata", wdata_d, 64'd0);
    @(posedge AClk); #1 ARst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(posedge AClk); #1;
      if (!vt[i].rd) begin
        set_wr(vt[i].r, vt[i].addr, vt[i].len, vt[i].data, 8'(8'hF0 | i));
        exp_wr_iss(vt[i].r, vt[i].addr, vt[i].len);
        issue_wait(1'b0, lat);
        check("wr_latency", 64'(lat), 64'd2);
        @(posedge AClk); #1 req_wr_valid = '0;
        check("wdata_grantee", wdata_d, vt[i].data);
        check("wstrb_grantee", 64'(wstrb_d), 64'(8'hF0 | i));
        check("wr_ctrl_zero", 64'({awlock_d, awcache_d, awprot_d}), 64'd0);
        t_done.mask = vt[i].exp_mask; t_done.resp = vt[i].resp;
        done_q.push_back(t_done);
        @(posedge AClk); #1;
        wr_rsp_en_d = 1'b1; bid_d = vt[i].id[3:0]; bresp_d = vt[i].resp;
        @(posedge AClk); #1 wr_rsp_en_d = 1'b0;
        repeat (2) @(posedge AClk); #1;
        check("wdata_idle", wdata_d, 64'd0);
      end else begin
        set_rd(vt[i].r, vt[i].addr, vt[i].len);
        issue_wait(1'b1, lat);
        check("rd_latency", 64'(lat), 64'd2);
        @(posedge AClk); #1 req_rd_valid = '0;
        t_beat.mask = vt[i].exp_mask; t_beat.data = vt[i].data;
        t_beat.resp = vt[i].resp; t_beat.last = 1'b1;
        beat_q.push_back(t_beat);
        @(posedge AClk); #1;
        rd_rsp_en_d = 1'b1; rid_d = vt[i].id; rdata_d = vt[i].data;
        rresp_d = vt[i].resp; r_last_d = 1'b1;
        @(posedge AClk); #1 rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
        repeat (2) @(posedge AClk); #1;
      end
      check("id_err_after_vec", 64'(id_err), 64'(vt[i].exp_err));
    end

    // Clear sticky id_err.
    ARst = 1'b1;
    @(posedge AClk); #1 ARst = 1'b0;
    check("id_err_cleared", 64'(id_err), 64'd0);

    // Four-beat read for requester 1, then an immediate new read proves R_IDLE.
    set_rd(1, 32'h0000_8000, 8'd3);
    issue_wait(1'b1, lat);
    check("rd4_latency", 64'(lat), 64'd2);
    @(posedge AClk); #1 req_rd_valid = '0;
    for (int b = 0; b < 4; b++) begin
      t_beat.mask = 4'b0010; t_beat.data = 64'(8'hA0 + b);
      t_beat.resp = 2'b00; t_beat.last = (b == 3);
      beat_q.push_back(t_beat);
      rd_rsp_en_d = 1'b1; rdata_d = 64'(8'hA0 + b); rresp_d = 2'b00;
      rid_d = 8'h01; r_last_d = (b == 3);
      @(posedge AClk); #1;
    end
    rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
    set_rd(0, 32'h0000_9000, 8'd0);
    issue_wait(1'b1, lat);
    check("rd_after_last_latency", 64'(lat), 64'd2);
    @(posedge AClk); #1 req_rd_valid = '0;
    t_beat.mask = 4'b0001; t_beat.data = 64'h77; t_beat.resp = 2'b00; t_beat.last = 1'b1;
    beat_q.push_back(t_beat);
    rd_rsp_en_d = 1'b1; rdata_d = 64'h77; rid_d = 8'h00; r_last_d = 1'b1;
    @(posedge AClk); #1 rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
    repeat (2) @(posedge AClk); #1;

    // Concurrent write (req 0) and read (req 3).
    set_wr(0, 32'h0000_C000, 8'd1, 64'h1111, 8'hFF);
    exp_wr_iss(0, 32'h0000_C000, 8'd1);
    set_rd(3, 32'h0000_D000, 8'd0);
    for (int n = 0; n < 30; n++) begin
      @(negedge AClk);
      if (wr_trn_en || rd_trn_en) break;
    end
    check("concurrent_issue", 64'({wr_trn_en, rd_trn_en}), 64'd3);
    @(posedge AClk); #1 req_wr_valid = '0; req_rd_valid = '0;
    t_done.mask = 4'b0001; t_done.resp = 2'b00; done_q.push_back(t_done);
    t_beat.mask = 4'b1000; t_beat.data = 64'h3333; t_beat.resp = 2'b01; t_beat.last = 1'b1;
    beat_q.push_back(t_beat);
    wr_rsp_en_d = 1'b1; bid_d = 4'd0; bresp_d = 2'b00;
    rd_rsp_en_d = 1'b1; rid_d = 8'h03; rdata_d = 64'h3333; rresp_d = 2'b01; r_last_d = 1'b1;
    @(posedge AClk); #1;
    wr_rsp_en_d = 1'b0; rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
    repeat (2) @(posedge AClk); #1;
    check("id_err_before_bad_bid", 64'(id_err), 64'd0);

    // Wrong bid: completion still goes to the grantee, id_err sticks.
    set_wr(0, 32'h0000_E000, 8'd0, 64'h55, 8'h0F);
    exp_wr_iss(0, 32'h0000_E000, 8'd0);
    issue_wait(1'b0, lat);
    @(posedge AClk); #1 req_wr_valid = '0;
    t_done.mask = 4'b0001; t_done.resp = 2'b00; done_q.push_back(t_done);
    wr_rsp_en_d = 1'b1; bid_d = 4'd1; bresp_d = 2'b00;
    @(posedge AClk); #1 wr_rsp_en_d = 1'b0;
    repeat (3) @(posedge AClk); #1;
    check("id_err_sticky", 64'(id_err), 64'd1);

    // Reset while waiting for a write response; the late response must vanish.
    set_wr(2, 32'h0000_F000, 8'd1, 64'h99, 8'h3C);
    exp_wr_iss(2, 32'h0000_F000, 8'd1);
    issue_wait(1'b0, lat);
    @(posedge AClk); #1 req_wr_valid = '0;
    ARst = 1'b1;
    @(posedge AClk);
    @(negedge AClk);
    check("midrst_pulses", 64'({wr_trn_en, wr_done, req_wr_ready}), 64'd0);
    check("midrst_id_err", 64'(id_err), 64'd0);
    check("midrst_cmd", 64'({awaddr_d, TXN_ID_W_d}), 64'd0);
    check("midrst_wdata", wdata_d, 64'd0);
    @(posedge AClk); #1 ARst = 1'b0;
    wr_rsp_en_d = 1'b1; bid_d = 4'd2; bresp_d = 2'b00;
    @(posedge AClk); #1 wr_rsp_en_d = 1'b0;
    seen = '0;
    repeat (3) begin
      @(negedge AClk);
      seen = seen | wr_done;
    end
    check("late_rsp_ignored", 64'(seen), 64'd0);

    // All four hold valid after reset: pointer restarts at 0 -> 0,1,2,3,0.
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    @(posedge AClk); #1;
    for (int r = 0; r < 4; r++)
      set_wr(r, 32'(32'h100 * (r + 1)), 8'(r), 64'(r + 16), 8'(r + 1));
    for (int k = 0; k < 5; k++)
      exp_wr_iss(order[k], 32'(32'h100 * (order[k] + 1)), 8'(order[k]));
    for (int k = 0; k < 5; k++) begin
      issue_wait(1'b0, lat);
      @(posedge AClk); #1;
      if (k == 4) req_wr_valid = '0;
      check("rr_wdata", wdata_d, 64'(order[k] + 16));
      t_done.mask = 4'(1 << order[k]); t_done.resp = 2'b00; done_q.push_back(t_done);
      wr_rsp_en_d = 1'b1; bid_d = 4'(order[k]); bresp_d = 2'b00;
      @(posedge AClk); #1 wr_rsp_en_d = 1'b0;
    end
    repeat (4) @(posedge AClk); #1;

    check("wr_iss_q_empty", 64'(wr_iss_q.size()), 64'd0);
    check("rd_iss_q_empty", 64'(rd_iss_q.size()), 64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    check("beat_q_empty", 64'(beat_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
